// File: rtl/mem_responder.sv
// Word-addressed memory slave with a four-phase Req/Ack handshake and a fixed access latency.
// Optional MEM_RESP_STATS_EN adds saturating in-range read/write counters (RdCount, WrCount).
module mem_responder #(
    parameter int DEPTH = 128,
    parameter int LAT   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req,
    input  logic        RNW,
    input  logic [10:0] Adx,
    input  logic [31:0] WData,
    output logic        Ack,
    output logic [31:0] RData,
    output logic        Err,
    output logic        Busy
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [15:0] RdCount,
    output logic [15:0] WrCount
`endif
);

    localparam int IDXW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            ack_nxt;
    logic [31:0]     rdata_nxt;
    logic            err_nxt;
    logic            do_access;

    logic            rnw_q;
    logic [10:0]     adx_q;
    logic [31:0]     wdata_q;
    logic [31:0]     mem [DEPTH];

    logic            capture;
    logic            in_range;
    logic            mem_we;
    logic [IDXW-1:0] idx;

    assign capture  = (state == IDLE) && Req;
    assign in_range = ({1'b0, adx_q} < 12'(DEPTH));
    assign idx      = adx_q[IDXW-1:0];
    assign Busy     = (state != IDLE);
    assign mem_we   = do_access && !rnw_q && in_range && !RST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 4'd0;
            Ack   <= 1'b0;
            RData <= 32'd0;
            Err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Ack   <= ack_nxt;
            RData <= rdata_nxt;
            Err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = Ack;
        rdata_nxt = RData;
        err_nxt   = Err;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (Req) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = 4'(LAT - 1);
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    // The same edge commits the write and launches the response.
                    do_access = 1'b1;
                    state_nxt = RESPOND;
                    ack_nxt   = 1'b1;
                    err_nxt   = !in_range;
                    rdata_nxt = (in_range && rnw_q) ? mem[idx] : 32'd0;
                end
            end
            RESPOND: begin
                if (!Req) begin
                    state_nxt = IDLE;
                    ack_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields and the array hold data only, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (capture) begin
            rnw_q   <= RNW;
            adx_q   <= Adx;
            wdata_q <= WData;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RdCount <= 16'd0;
            WrCount <= 16'd0;
        end else if (do_access && in_range) begin
            if (rnw_q && RdCount != 16'hFFFF) begin
                RdCount <= RdCount + 16'd1;
            end
            if (!rnw_q && WrCount != 16'hFFFF) begin
                WrCount <= WrCount + 16'd1;
            end
        end
    end
`endif

endmodule
